frog_mover: RTL and testbench

FROG_MOVER -- requirements
Module: frog_mover

---
 rtl/frog_pkg.sv | 33 +++
 rtl/frog_hit.sv | 42 ++++
 rtl/frog_mover.sv | 178 +++++++++++++++++
 tb/tb_frog_mover.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// frog_pkg: shared types and screen defaults for the frog sprite mover.
//   state_e : movement FSM states
//   dir_e   : latched movement direction
//   DEF_*   : default 640x480 screen bounds and spawn point for a 15x15 sprite
package frog_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOP,
      ST_HOLD,
      ST_GLIDE
   } state_e;

   typedef enum logic [1:0] {
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   localparam int POS_W       = 10;   // raster / position width
   localparam int CALC_W      = 11;   // signed working width for moves and compares
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int SPRITE_DIM  = 15;
   localparam int DEF_X_MIN   = 0;
   localparam int DEF_Y_MIN   = 0;
   localparam int DEF_X_MAX   = SCREEN_W - SPRITE_DIM;   // 625: sprite fully on screen
   localparam int DEF_Y_MAX   = SCREEN_H - SPRITE_DIM;   // 465
   localparam int DEF_START_X = 300;
   localparam int DEF_START_Y = 449;

endpackage

// File: rtl/frog_hit.sv
// frog_hit: registered raster-vs-sprite hit test.
//   clk, rst          : clock, synchronous active-high reset
//   pos_x, pos_y      : sprite top-left corner
//   x_count, y_count  : current raster pixel
//   frog              : raster pixel lies on the sprite, one clk after the inputs
module frog_hit
   import frog_pkg::*;
#(
   parameter int SPRITE_W = SPRITE_DIM,
   parameter int SPRITE_H = SPRITE_DIM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [POS_W-1:0]  pos_x,
   input  logic [POS_W-1:0]  pos_y,
   input  logic [POS_W-1:0]  x_count,
   input  logic [POS_W-1:0]  y_count,
   output logic              frog
);

   logic [CALC_W-1:0] x_lo, x_hi, y_lo, y_hi, xc, yc;
   logic              frog_d, frog_q;

   // Widened by one bit so pos + size near the right/bottom edge cannot wrap.
   always_comb begin
      x_lo   = {1'b0, pos_x};
      y_lo   = {1'b0, pos_y};
      x_hi   = x_lo + CALC_W'(SPRITE_W);
      y_hi   = y_lo + CALC_W'(SPRITE_H);
      xc     = {1'b0, x_count};
      yc     = {1'b0, y_count};
      frog_d = (xc >= x_lo) && (xc < x_hi) && (yc >= y_lo) && (yc < y_hi);
   end

   always_ff @(posedge clk) begin
      if (rst) frog_q <= 1'b0;
      else     frog_q <= frog_d;
   end

   assign frog = frog_q;

endmodule

// File: rtl/frog_mover.sv
// frog_mover: button-driven sprite mover with hop/glide FSM and clamped position.
//   clk, rst            : clock, synchronous active-high reset
//   tick                : one-clk frame strobe; position and FSM advance only on it
//   up_n..right_n       : active-low buttons
//   respawn             : return to spawn point and IDLE (any cycle)
//   x_count, y_count    : current raster pixel
//   frog                : raster pixel on sprite (1 clk latency)
//   pos_x, pos_y        : sprite top-left corner
//   moving              : FSM in HOP or GLIDE
//   home                : one-clk pulse when a move lands on Y_MIN from below
module frog_mover
   import frog_pkg::*;
#(
   parameter int SPRITE_W  = SPRITE_DIM,
   parameter int SPRITE_H  = SPRITE_DIM,
   parameter int STEP      = 2,
   parameter int HOP_TICKS = 8,
   parameter int X_MIN     = DEF_X_MIN,
   parameter int X_MAX     = DEF_X_MAX,
   parameter int Y_MIN     = DEF_Y_MIN,
   parameter int Y_MAX     = DEF_Y_MAX,
   parameter int START_X   = DEF_START_X,
   parameter int START_Y   = DEF_START_Y,
   parameter int CONT_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              up_n,
   input  logic              down_n,
   input  logic              left_n,
   input  logic              right_n,
   input  logic              respawn,
   input  logic [POS_W-1:0]  x_count,
   input  logic [POS_W-1:0]  y_count,
   output logic              frog,
   output logic [POS_W-1:0]  pos_x,
   output logic [POS_W-1:0]  pos_y,
   output logic              moving,
   output logic              home
);

   localparam logic signed [CALC_W-1:0] STEP_S  = CALC_W'(STEP);
   localparam logic signed [CALC_W-1:0] X_LO    = CALC_W'(X_MIN);
   localparam logic signed [CALC_W-1:0] X_HI    = CALC_W'(X_MAX);
   localparam logic signed [CALC_W-1:0] Y_LO    = CALC_W'(Y_MIN);
   localparam logic signed [CALC_W-1:0] Y_HI    = CALC_W'(Y_MAX);
   localparam logic [7:0]               HOP_CNT = 8'(HOP_TICKS);

   function automatic logic [POS_W-1:0] clamp(input logic signed [CALC_W-1:0] v,
                                              input logic signed [CALC_W-1:0] lo,
                                              input logic signed [CALC_W-1:0] hi);
      if (v < lo)      return lo[POS_W-1:0];
      else if (v > hi) return hi[POS_W-1:0];
      else             return v[POS_W-1:0];
   endfunction

   state_e                    state_q, state_d;
   dir_e                      dir_q, dir_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [POS_W-1:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic                      home_q, home_d, moving_q, moving_d;
   logic signed [CALC_W-1:0]  dx, dy;
   logic [POS_W-1:0]          mv_x, mv_y;
   logic                      any_btn, held_btn, home_hit;

   always_comb begin
      dx = '0;
      dy = '0;
      case (dir_q)
         DIR_UP:    dy = -STEP_S;
         DIR_DOWN:  dy = STEP_S;
         DIR_LEFT:  dx = -STEP_S;
         default:   dx = STEP_S;
      endcase
      mv_x     = clamp($signed({1'b0, pos_x_q}) + dx, X_LO, X_HI);
      mv_y     = clamp($signed({1'b0, pos_y_q}) + dy, Y_LO, Y_HI);
      // Only a move that arrives at the top edge counts; sitting there does not.
      home_hit = (mv_y == Y_LO[POS_W-1:0]) && (pos_y_q > Y_LO[POS_W-1:0]);

      any_btn  = ~(up_n & down_n & left_n & right_n);
      case (dir_q)
         DIR_UP:    held_btn = ~up_n;
         DIR_DOWN:  held_btn = ~down_n;
         DIR_LEFT:  held_btn = ~left_n;
         default:   held_btn = ~right_n;
      endcase

      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      home_d  = 1'b0;

      if (respawn) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pos_x_d = POS_W'(START_X);
         pos_y_d = POS_W'(START_Y);
      end else if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (any_btn) begin
                  if (!up_n)        dir_d = DIR_UP;
                  else if (!down_n) dir_d = DIR_DOWN;
                  else if (!left_n) dir_d = DIR_LEFT;
                  else              dir_d = DIR_RIGHT;
                  state_d = (CONT_MODE != 0) ? ST_GLIDE : ST_HOP;
                  cnt_d   = HOP_CNT;
               end
            end
            ST_HOP: begin
               // Buttons are ignored here; a clamped step still spends its tick.
               pos_x_d = mv_x;
               pos_y_d = mv_y;
               home_d  = home_hit;
               cnt_d   = cnt_q - 8'd1;
               if (cnt_q <= 8'd1) state_d = ST_HOLD;
            end
            ST_HOLD: begin
               if (!any_btn) state_d = ST_IDLE;
            end
            ST_GLIDE: begin
               if (held_btn) begin
                  pos_x_d = mv_x;
                  pos_y_d = mv_y;
                  home_d  = home_hit;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      moving_d = (state_d == ST_HOP) || (state_d == ST_GLIDE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_UP;
         cnt_q    <= '0;
         pos_x_q  <= POS_W'(START_X);
         pos_y_q  <= POS_W'(START_Y);
         home_q   <= 1'b0;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         home_q   <= home_d;
         moving_q <= moving_d;
      end
   end

   frog_hit #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
   ) u_hit (
      .clk     (clk),
      .rst     (rst),
      .pos_x   (pos_x_q),
      .pos_y   (pos_y_q),
      .x_count (x_count),
      .y_count (y_count),
      .frog    (frog)
   );

   assign pos_x  = pos_x_q;
   assign pos_y  = pos_y_q;
   assign moving = moving_q;
   assign home   = home_q;

endmodule

// File: tb/tb_frog_mover.sv
// tb_frog_mover: scoreboard bench for frog_mover.
// Three instances share buttons/raster/respawn/rst but have private ticks:
//   u_hop   : defaults, discrete hops
//   u_edge  : spawn at (4,2) to reach the left and top edges quickly
//   u_glide : CONT_MODE=1
module tb_frog_mover;

   logic       clk = 1'b0;
   logic       rst, respawn, up_n, down_n, left_n, right_n;
   logic       tick_h, tick_e, tick_g;
   logic [9:0] x_count, y_count;

   logic       frog_h, mov_h, home_h;
   logic [9:0] px_h, py_h;
   logic       frog_e, mov_e, home_e;
   logic [9:0] px_e, py_e;
   logic       frog_g, mov_g, home_g;
   logic [9:0] px_g, py_g;

   always #5 clk = ~clk;

   frog_mover u_hop (
      .clk(clk), .rst(rst), .tick(tick_h), .up_n(up_n), .down_n(down_n),
      .left_n(left_n), .right_n(right_n), .respawn(respawn),
      .x_count(x_count), .y_count(y_count), .frog(frog_h),
      .pos_x(px_h), .pos_y(py_h), .moving(mov_h), .home(home_h));

   frog_mover #(.START_X(4), .START_Y(2)) u_edge (
      .clk(clk), .rst(rst), .tick(tick_e), .up_n(up_n), .down_n(down_n),
      .left_n(left_n), .right_n(right_n), .respawn(respawn),
      .x_count(x_count), .y_count(y_count), .frog(frog_e),
      .pos_x(px_e), .pos_y(py_e), .moving(mov_e), .home(home_e));

   frog_mover #(.CONT_MODE(1)) u_glide (
      .clk(clk), .rst(rst), .tick(tick_g), .up_n(up_n), .down_n(down_n),
      .left_n(left_n), .right_n(right_n), .respawn(respawn),
      .x_count(x_count), .y_count(y_count), .frog(frog_g),
      .pos_x(px_g), .pos_y(py_g), .moving(mov_g), .home(home_g));

   localparam int S_HX = 0, S_HY = 1, S_HMOV = 2, S_HHOME = 3, S_HFROG = 4;
   localparam int S_EX = 5, S_EY = 6, S_EMOV = 7, S_EHOME = 8;
   localparam int S_GX = 9, S_GY = 10, S_GMOV = 11, S_GHOME = 12;

   typedef struct {
      string       tag;
      int          src;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic logic [31:0] obs(input int src);
      case (src)
         S_HX:    return 32'(px_h);
         S_HY:    return 32'(py_h);
         S_HMOV:  return 32'(mov_h);
         S_HHOME: return 32'(home_h);
         S_HFROG: return 32'(frog_h);
         S_EX:    return 32'(px_e);
         S_EY:    return 32'(py_e);
         S_EMOV:  return 32'(mov_e);
         S_EHOME: return 32'(home_e);
         S_GX:    return 32'(px_g);
         S_GY:    return 32'(py_g);
         S_GMOV:  return 32'(mov_g);
         S_GHOME: return 32'(home_g);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic push_exp(input string tag, input int src, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.src = src;
      e.exp = v;
      sb.push_back(e);
   endtask

   // One clock with the chosen ticks; then drain the scoreboard against the outputs.
   task automatic step(input bit th, input bit te, input bit tg);
      exp_t e;
      tick_h = th;
      tick_e = te;
      tick_g = tg;
      @(posedge clk);
      #1;
      tick_h = 1'b0;
      tick_e = 1'b0;
      tick_g = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.src), e.exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; respawn = 1'b0;
      up_n = 1'b1; down_n = 1'b1; left_n = 1'b1; right_n = 1'b1;
      tick_h = 1'b0; tick_e = 1'b0; tick_g = 1'b0;
      x_count = 10'd0; y_count = 10'd0;
      step(0, 0, 0);
      step(0, 0, 0);

      // Reset state
      push_exp("rst_hx", S_HX, 300);   push_exp("rst_hy", S_HY, 449);
      push_exp("rst_hmov", S_HMOV, 0); push_exp("rst_hhome", S_HHOME, 0);
      push_exp("rst_hfrog", S_HFROG, 0);
      push_exp("rst_ex", S_EX, 4);     push_exp("rst_ey", S_EY, 2);
      push_exp("rst_gx", S_GX, 300);   push_exp("rst_gmov", S_GMOV, 0);
      step(1, 1, 1);
      rst = 1'b0;

      // Glide: latch tick, 5 held ticks moving right, stop on release
      right_n = 1'b0;
      push_exp("gl_latch_mov", S_GMOV, 1); push_exp("gl_latch_x", S_GX, 300);
      step(0, 0, 1);
      for (int k = 1; k <= 5; k++) begin
         push_exp("gl_x", S_GX, 300 + 2 * k); push_exp("gl_y", S_GY, 449);
         push_exp("gl_mov", S_GMOV, 1);
         step(0, 0, 1);
      end
      right_n = 1'b1;
      push_exp("gl_rel_x", S_GX, 310); push_exp("gl_rel_mov", S_GMOV, 0);
      step(0, 0, 1);
      push_exp("gl_idle_x", S_GX, 310);
      step(0, 0, 1);

      // Clamp at X_MIN: start x=4, left hop
      left_n = 1'b0;
      push_exp("cl_latch_mov", S_EMOV, 1); push_exp("cl_latch_x", S_EX, 4);
      step(0, 1, 0);
      left_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         push_exp("cl_x", S_EX, (4 - 2 * k) < 0 ? 0 : 4 - 2 * k);
         push_exp("cl_mov", S_EMOV, (k < 8) ? 1 : 0);
         step(0, 1, 0);
      end
      push_exp("cl_hold_x", S_EX, 0);
      step(0, 1, 0);

      // Home: y=2, up hop, single pulse on landing at 0
      up_n = 1'b0;
      push_exp("hm_latch_y", S_EY, 2); push_exp("hm_latch_home", S_EHOME, 0);
      step(0, 1, 0);
      up_n = 1'b1;
      push_exp("hm_y1", S_EY, 0); push_exp("hm_pulse", S_EHOME, 1);
      step(0, 1, 0);
      push_exp("hm_notick_home", S_EHOME, 0);
      step(0, 0, 0);
      for (int k = 2; k <= 8; k++) begin
         push_exp("hm_y", S_EY, 0); push_exp("hm_nopulse", S_EHOME, 0);
         step(0, 1, 0);
      end
      step(0, 1, 0);

      // Basic hop 449 -> 433, moving high for 8 ticks, one idle-time tick
      up_n = 1'b0;
      push_exp("hop_latch_mov", S_HMOV, 1); push_exp("hop_latch_y", S_HY, 449);
      step(1, 0, 0);
      up_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         push_exp("hop_y", S_HY, 449 - 2 * k); push_exp("hop_x", S_HX, 300);
         push_exp("hop_mov", S_HMOV, (k < 8) ? 1 : 0);
         step(1, 0, 0);
         if (k == 4) begin
            push_exp("hop_notick_y", S_HY, 441); push_exp("hop_notick_mov", S_HMOV, 1);
            step(0, 0, 0);
         end
      end
      push_exp("hop_end_y", S_HY, 433); push_exp("hop_end_mov", S_HMOV, 0);
      step(1, 0, 0);
      push_exp("hop_idle_y", S_HY, 433);
      step(1, 0, 0);

      // Held button: one hop only, then HOLD until release
      respawn = 1'b1;
      push_exp("rsp_x", S_HX, 300); push_exp("rsp_y", S_HY, 449);
      step(0, 0, 0);
      respawn = 1'b0;
      up_n = 1'b0;
      for (int t = 1; t <= 30; t++) begin
         push_exp("held_y", S_HY, (t <= 1) ? 449 : (t <= 9) ? 449 - 2 * (t - 1) : 433);
         push_exp("held_mov", S_HMOV, (t <= 8) ? 1 : 0);
         step(1, 0, 0);
      end
      up_n = 1'b1;
      push_exp("held_rel_y", S_HY, 433); push_exp("held_rel_mov", S_HMOV, 0);
      step(1, 0, 0);
      down_n = 1'b0;
      push_exp("held_idle_mov", S_HMOV, 1);
      step(1, 0, 0);
      down_n = 1'b1;
      push_exp("held_down_y", S_HY, 435);
      step(1, 0, 0);

      // Priority down>left>right and clamp at Y_MAX
      respawn = 1'b1;
      step(0, 0, 0);
      respawn = 1'b0;
      down_n = 1'b0; left_n = 1'b0; right_n = 1'b0;
      push_exp("pri_mov", S_HMOV, 1);
      step(1, 0, 0);
      down_n = 1'b1; left_n = 1'b1; right_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         push_exp("pri_y", S_HY, 449 + 2 * k); push_exp("pri_x", S_HX, 300);
         step(1, 0, 0);
      end
      step(1, 0, 0);
      down_n = 1'b0;
      step(1, 0, 0);
      down_n = 1'b1;
      push_exp("ymax_y", S_HY, 465); push_exp("ymax_mov", S_HMOV, 1);
      step(1, 0, 0);

      // Hit test at (300,449)
      respawn = 1'b1;
      step(0, 0, 0);
      respawn = 1'b0;
      y_count = 10'd449;
      for (int x = 298; x <= 316; x++) begin
         x_count = 10'(x);
         push_exp("hit_x", S_HFROG, (x >= 300 && x <= 314) ? 1 : 0);
         step(0, 0, 0);
      end
      x_count = 10'd305;
      y_count = 10'd448; push_exp("hit_y448", S_HFROG, 0); step(0, 0, 0);
      y_count = 10'd463; push_exp("hit_y463", S_HFROG, 1); step(0, 0, 0);
      y_count = 10'd464; push_exp("hit_y464", S_HFROG, 0); step(0, 0, 0);

      // Respawn mid-hop overrides the move
      up_n = 1'b0;
      step(1, 0, 0);
      up_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         push_exp("rmh_y", S_HY, 449 - 2 * k);
         step(1, 0, 0);
      end
      respawn = 1'b1; up_n = 1'b0;
      push_exp("rmh_x", S_HX, 300); push_exp("rmh_y0", S_HY, 449);
      push_exp("rmh_mov", S_HMOV, 0);
      step(1, 0, 0);
      respawn = 1'b0; up_n = 1'b1;
      push_exp("rmh_idle_y", S_HY, 449); push_exp("rmh_idle_mov", S_HMOV, 0);
      step(1, 0, 0);

      // rst mid-hop: overrides respawn/tick, no residual movement
      x_count = 10'd300; y_count = 10'd449;
      up_n = 1'b0;
      step(1, 0, 0);
      up_n = 1'b1;
      step(1, 0, 0);
      step(1, 0, 0);
      rst = 1'b1; respawn = 1'b1;
      push_exp("rmr_x", S_HX, 300); push_exp("rmr_y", S_HY, 449);
      push_exp("rmr_mov", S_HMOV, 0); push_exp("rmr_home", S_HHOME, 0);
      push_exp("rmr_frog", S_HFROG, 0);
      step(1, 0, 0);
      rst = 1'b0; respawn = 1'b0;
      push_exp("rmr_after_y", S_HY, 449); push_exp("rmr_after_mov", S_HMOV, 0);
      push_exp("rmr_after_frog", S_HFROG, 1);
      step(1, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
